// File: rtl/edge_mon_pkg.sv
// Shared types and defaults for the edge event monitor.
// State encoding is fixed: IDLE=0, ARMED=1, COUNT=2, DONE=3.
package edge_mon_pkg;

    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/edge_monitor_detect.sv
// Edge detector: optional 2-flop input synchronizer (EDGE_SYNC_EN), d_prev,
// registered rise/fall pulses and the combinational rising-edge event re.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic re
);

    logic din_s;
    logic d_prev;

`ifdef EDGE_SYNC_EN
    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            din_s <= 1'b0;
        end else begin
            meta  <= din;
            din_s <= meta;
        end
    end
`else
    assign din_s = din;
`endif

    // d_prev resets low, so a level already high after reset reads as a rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_prev <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            d_prev <= din_s;
            rise   <= din_s & ~d_prev;
            fall   <= ~din_s & d_prev;
        end
    end

    assign re = din_s & ~d_prev;

endmodule

// File: rtl/edge_event_monitor.sv
// Edge event monitor: rise/fall pulses plus an armed rising-edge counter
// that raises done at TARGET edges. Optional input synchronizer: EDGE_SYNC_EN.
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = DEFAULT_CNT_W,
    parameter int unsigned TARGET = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             din,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [1:0]       state,
    output logic             done
);

    localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic             re;
    mon_state_t       state_q;
    mon_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    edge_detect u_detect (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .rise  (rise),
        .fall  (fall),
        .re    (re)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = cnt_q + ONE_C;

    // Priority per edge: clear, then start (restart), then the rising-edge event
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end
                end
                ARMED: begin
                    if (start) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else if (re) begin
                        cnt_d   = ONE_C;
                        state_d = (ONE_C == TARGET_C) ? DONE : COUNT;
                    end
                end
                COUNT: begin
                    if (start) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                    end else if (re) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TARGET_C) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign edge_cnt = cnt_q;
    assign state    = state_q;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_edge_event_monitor.sv
// Directed self-checking bench for edge_event_monitor (TARGET=4 and TARGET=1).
// Follows EDGE_SYNC_EN: din changes are given two extra cycles when it is defined.
module tb_edge_event_monitor;

`ifdef EDGE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       clear;
    logic       din;
    logic       rise,  fall,  done;
    logic [7:0] edge_cnt;
    logic [1:0] state;
    logic       rise1, fall1, done1;
    logic [7:0] edge_cnt1;
    logic [1:0] state1;

    int vectors = 0;
    int errors  = 0;

    edge_event_monitor #(.CNT_W(8), .TARGET(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .din      (din),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt),
        .state    (state),
        .done     (done)
    );

    edge_event_monitor #(.CNT_W(8), .TARGET(1)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .din      (din),
        .rise     (rise1),
        .fall     (fall1),
        .edge_cnt (edge_cnt1),
        .state    (state1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Change din and let it travel through the synchronizer, so the next step() samples the edge
    task automatic set_din(input logic v);
        din = v;
        repeat (SYNC) step();
    endtask

    task automatic check_main(input string tag, input int exp_cnt, input int exp_state);
        check({tag, "_cnt"},   32'(edge_cnt), 32'(exp_cnt));
        check({tag, "_state"}, 32'(state),    32'(exp_state));
        check({tag, "_done"},  32'(done),     32'(exp_state == 3));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        din   = 1'b1;
        #3;
        check("rst_rise",  32'(rise),     32'd0);
        check("rst_fall",  32'(fall),     32'd0);
        check_main("rst", 0, 0);

        // First edge after release sees din=1 against d_prev=0
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (SYNC) step();
        step();
        check("first_rise", 32'(rise), 32'd1);
        check_main("first", 0, 0);
        step();
        check("first_rise_end", 32'(rise), 32'd0);

        set_din(1'b0);
        step();
        check("fall_pulse", 32'(fall), 32'd1);
        check("fall_norise", 32'(rise), 32'd0);
        step();
        check("fall_end", 32'(fall), 32'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        check_main("arm", 0, 1);
        check("arm1_state", 32'(state1), 32'd1);

        for (int i = 1; i <= 4; i++) begin
            set_din(1'b0);
            step();
            set_din(1'b1);
            step();
            check("cnt_rise", 32'(rise), 32'd1);
            check_main("cnt", i, (i < 4) ? 2 : 3);
            if (i == 1) begin
                check("t1_cnt",   32'(edge_cnt1), 32'd1);
                check("t1_state", 32'(state1),    32'd3);
                check("t1_done",  32'(done1),     32'd1);
            end
        end

        for (int i = 0; i < 2; i++) begin
            set_din(1'b0);
            step();
            set_din(1'b1);
            step();
            check_main("done_hold", 4, 3);
            check("t1_hold_cnt", 32'(edge_cnt1), 32'd1);
        end

        start = 1'b1;
        step();
        start = 1'b0;
        check_main("done_start", 4, 3);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check_main("clear", 0, 0);
        check("t1_clear", 32'(state1), 32'd0);

        start = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_main("clr_start", 0, 0);
        step();
        start = 1'b0;
        check_main("rearm", 0, 1);

        set_din(1'b0);
        step();
        for (int i = 1; i <= 2; i++) begin
            set_din(1'b0);
            step();
            set_din(1'b1);
            step();
            check_main("cnt2", i, 2);
        end

        // Restart on the same edge as a rising din: the edge is not counted
        set_din(1'b0);
        step();
        set_din(1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_rise", 32'(rise), 32'd1);
        check_main("restart", 0, 1);

        for (int i = 1; i <= 3; i++) begin
            set_din(1'b0);
            step();
            set_din(1'b1);
            step();
            check_main("recount", i, 2);
        end
        check("pre_rst_rise", 32'(rise), 32'd1);

        #2;
        reset = 1'b1;
        #1;
        check("async_rise", 32'(rise), 32'd0);
        check("async_fall", 32'(fall), 32'd0);
        check_main("async", 0, 0);
        check("async_t1_state", 32'(state1), 32'd0);
        check("async_t1_cnt",   32'(edge_cnt1), 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        din   = 1'b0;
        step();
        check_main("post_rst", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
